alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 5-bit ALU operation code from the ALU control block and the two XLEN operands.
- Single-cycle register-output path for base RV32I ops.
- Iterative 32-cycle path for RV32M multiply/divide.
- valid/ready handshake on both sides, so the pipeline stalls while a long op is busy.

---
 rtl/alu_exec_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: RV32I ops in one cycle, optional RV32M mul/div (ALU_MULDIV_EN) iterating one bit per cycle.
// Latency 1 for base ops, illegal codes, div-by-zero and signed overflow; ITERS+1 for iterative mul/div.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, then one bubble before the next accept.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
`ifdef ALU_MULDIV_EN
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;
`endif

  typedef enum logic [1:0] {IDLE, MULT, DIVD, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] result_nxt;
  logic            illegal_nxt;
  logic [XLEN-1:0] base_res;
  logic            base_ok;
  logic [SHW-1:0]  shamt;

  assign shamt     = op_b[SHW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    base_res = '0;
    base_ok  = 1'b1;
    case (alu_op)
      OP_ADD:  base_res = op_a + op_b;
      OP_SUB:  base_res = op_a - op_b;
      OP_SLL:  base_res = op_a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  base_res = op_a ^ op_b;
      OP_SRL:  base_res = op_a >> shamt;
      OP_SRA:  base_res = $signed(op_a) >>> shamt;
      OP_OR:   base_res = op_a | op_b;
      OP_AND:  base_res = op_a & op_b;
      default: base_ok  = 1'b0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int ITERS = XLEN;
  localparam int CW    = $clog2(ITERS);
  localparam logic [CW-1:0]   LAST = CW'(ITERS - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            is_mul, is_div, a_sgn, b_sgn, div_rem, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, div_quick;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod, mcand;
  logic [XLEN-1:0]   mplier;
  logic              mul_neg, mul_hi;
  logic [XLEN-1:0]   dq, drem, dvsr;
  logic              neg_q, neg_r, want_rem;

  logic [2*XLEN-1:0] prod_add, mul_fin;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_take;
  logic [XLEN-1:0]   q_new, r_new, mul_res, div_res;

  always_comb begin
    is_mul    = alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    is_div    = alu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    a_sgn     = alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn     = alu_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_mag     = (a_sgn && op_a[XLEN-1]) ? -op_a : op_a;
    b_mag     = (b_sgn && op_b[XLEN-1]) ? -op_b : op_b;
    div_rem   = alu_op inside {OP_REM, OP_REMU};
    div_zero  = (op_b == '0);
    div_ovf   = (alu_op inside {OP_DIV, OP_REM}) && (op_a == SMIN) && (op_b == '1);
    div_quick = div_zero ? (div_rem ? op_a : '1) : (div_rem ? '0 : SMIN);
  end

  // One iteration of each loop; the last iteration also applies the sign fix.
  always_comb begin
    prod_add  = prod + (mplier[0] ? mcand : '0);
    mul_fin   = mul_neg ? -prod_add : prod_add;
    mul_res   = mul_hi ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];
    div_shift = {drem, dq[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvsr};
    div_take  = ~div_diff[XLEN];
    q_new     = {dq[XLEN-2:0], div_take};
    r_new     = div_take ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_res   = want_rem ? (neg_r ? -r_new : r_new) : (neg_q ? -q_new : q_new);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mul_neg  <= 1'b0;
      mul_hi   <= 1'b0;
      dq       <= '0;
      drem     <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cnt <= '0;
          if (is_mul) begin
            prod    <= '0;
            mcand   <= {{XLEN{1'b0}}, a_mag};
            mplier  <= b_mag;
            mul_neg <= (a_sgn & op_a[XLEN-1]) ^ (b_sgn & op_b[XLEN-1]);
            mul_hi  <= (alu_op != OP_MUL);
          end
          if (is_div) begin
            dq       <= a_mag;
            drem     <= '0;
            dvsr     <= b_mag;
            neg_q    <= a_sgn & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            neg_r    <= a_sgn & op_a[XLEN-1];
            want_rem <= div_rem;
          end
        end
        MULT: begin
          prod   <= prod_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        DIVD: begin
          dq   <= q_new;
          drem <= r_new;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    result_nxt  = result;
    illegal_nxt = illegal;
    case (state)
      IDLE: if (in_valid) begin
        state_nxt   = DONE;
        illegal_nxt = 1'b0;
        if (base_ok) result_nxt = base_res;
`ifdef ALU_MULDIV_EN
        else if (is_mul) state_nxt = MULT;
        else if (is_div) begin
          if (div_zero || div_ovf) result_nxt = div_quick;
          else state_nxt = DIVD;
        end
`endif
        else begin
          result_nxt  = '0;
          illegal_nxt = 1'b1;
        end
      end
`ifdef ALU_MULDIV_EN
      MULT: if (cnt == LAST) begin
        state_nxt  = DONE;
        result_nxt = mul_res;
      end
      DIVD: if (cnt == LAST) begin
        state_nxt  = DONE;
        result_nxt = div_res;
      end
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      result  <= result_nxt;
      illegal <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; mul/div vectors follow whether ALU_MULDIV_EN is defined.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end (observed=timeout expected=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op from IDLE, waits (bounded) for out_valid, then lets it drain with out_ready=1.
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int lat, output logic [31:0] res, output logic ill, output logic rdy_seen);
    alu_op = op; op_a = a; op_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 60) begin
      rdy_seen |= in_ready;
      tick();
      lat++;
    end
    rdy_seen |= in_ready;
    res = result;
    ill = illegal;
    tick();
  endtask

  int          lat;
  logic [31:0] res;
  logic        ill, rdy_seen;
  logic        flag;
  logic [31:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_op = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_result",    result,             32'd0);
    chk("rst_illegal",   {31'd0, illegal},   32'd0);

    // Reset in the middle of a long op (or a held result without mul/div).
    out_ready = 1'b0;
    alu_op = 5'd10; op_a = 32'd7; op_b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort_result",    result,             32'd0);
    out_ready = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      flag |= out_valid;
      tick();
    end
    chk("abort_no_output", {31'd0, flag}, 32'd0);

    // Base ops
    run(5'd0, 32'hFFFF_FFFF, 32'h1, lat, res, ill, rdy_seen);
    chk("add_wrap", res, 32'h0);
    chk("add_lat", 32'(lat), 32'd1);
    chk("add_ill", {31'd0, ill}, 32'd0);
    run(5'd7, 32'h8000_0000, 32'h24, lat, res, ill, rdy_seen);
    chk("sra", res, 32'hF800_0000);
    run(5'd3, 32'hFFFF_FFFF, 32'h1, lat, res, ill, rdy_seen);
    chk("slt", res, 32'h1);
    run(5'd4, 32'hFFFF_FFFF, 32'h1, lat, res, ill, rdy_seen);
    chk("sltu", res, 32'h0);
    run(5'd1, 32'h0, 32'h1, lat, res, ill, rdy_seen);
    chk("sub_wrap", res, 32'hFFFF_FFFF);
    run(5'd2, 32'h1, 32'h21, lat, res, ill, rdy_seen);
    chk("sll_shamt", res, 32'h2);
    run(5'd6, 32'h8000_0000, 32'h4, lat, res, ill, rdy_seen);
    chk("srl", res, 32'h0800_0000);
    run(5'd8, 32'hF000_000F, 32'h0F00_00F0, lat, res, ill, rdy_seen);
    chk("or", res, 32'hFF00_00FF);
    run(5'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, res, ill, rdy_seen);
    chk("and", res, 32'hF000_F000);

`ifdef ALU_MULDIV_EN
    run(5'd10, 32'd7, 32'hFFFF_FFFD, lat, res, ill, rdy_seen);
    chk("mul", res, 32'hFFFF_FFEB);
    chk("mul_lat", 32'(lat), 32'd33);
    chk("mul_busy", {31'd0, rdy_seen}, 32'd0);
    run(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, ill, rdy_seen);
    chk("mulhu", res, 32'hFFFF_FFFE);
    run(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, ill, rdy_seen);
    chk("mulh", res, 32'h0);
    run(5'd12, 32'hFFFF_FFFF, 32'h2, lat, res, ill, rdy_seen);
    chk("mulhsu", res, 32'hFFFF_FFFF);
    run(5'd14, 32'hFFFF_FFF9, 32'd2, lat, res, ill, rdy_seen);
    chk("div", res, 32'hFFFF_FFFD);
    chk("div_lat", 32'(lat), 32'd33);
    run(5'd16, 32'hFFFF_FFF9, 32'd2, lat, res, ill, rdy_seen);
    chk("rem", res, 32'hFFFF_FFFF);
    run(5'd15, 32'd100, 32'd7, lat, res, ill, rdy_seen);
    chk("divu", res, 32'd14);
    run(5'd17, 32'd100, 32'd7, lat, res, ill, rdy_seen);
    chk("remu", res, 32'd2);
    run(5'd15, 32'd5, 32'd0, lat, res, ill, rdy_seen);
    chk("divu_zero", res, 32'hFFFF_FFFF);
    chk("divu_zero_lat", 32'(lat), 32'd1);
    run(5'd17, 32'd5, 32'd0, lat, res, ill, rdy_seen);
    chk("remu_zero", res, 32'd5);
    chk("remu_zero_lat", 32'(lat), 32'd1);
    run(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, ill, rdy_seen);
    chk("div_ovf", res, 32'h8000_0000);
    chk("div_ovf_lat", 32'(lat), 32'd1);
    run(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, ill, rdy_seen);
    chk("rem_ovf", res, 32'h0);
`else
    run(5'd10, 32'd7, 32'd3, lat, res, ill, rdy_seen);
    chk("mul_off_ill", {31'd0, ill}, 32'd1);
    chk("mul_off_res", res, 32'h0);
    chk("mul_off_lat", 32'(lat), 32'd1);
    run(5'd14, 32'd7, 32'd0, lat, res, ill, rdy_seen);
    chk("div_off_ill", {31'd0, ill}, 32'd1);
    chk("div_off_lat", 32'(lat), 32'd1);
`endif

    // Backpressure: result held, new offers ignored
    out_ready = 1'b0;
    alu_op = 5'd5; op_a = 32'hF0F0_F0F0; op_b = 32'h0FF0_0FF0; in_valid = 1'b1;
    tick();
    chk("bp_first", result, 32'hFF00_FF00);
    held = result;
    alu_op = 5'd0; op_a = 32'd1; op_b = 32'd1;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      flag |= (result !== 32'hFF00_FF00) || !out_valid || in_ready;
    end
    chk("bp_hold", {31'd0, flag}, 32'd0);
    chk("bp_value", result, held);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", {31'd0, in_ready},  32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    run(5'd0, 32'd2, 32'd3, lat, res, ill, rdy_seen);
    chk("bp_next_op", res, 32'd5);
    chk("bp_next_lat", 32'(lat), 32'd1);

    // Undefined code, then illegal clears on a legal op
    run(5'd20, 32'd9, 32'd9, lat, res, ill, rdy_seen);
    chk("op20_ill", {31'd0, ill}, 32'd1);
    chk("op20_res", res, 32'h0);
    chk("op20_lat", 32'(lat), 32'd1);
    run(5'd0, 32'd9, 32'd9, lat, res, ill, rdy_seen);
    chk("ill_clear", {31'd0, ill}, 32'd0);
    chk("ill_clear_res", res, 32'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
